// File: rtl/axis_dbg_guv.sv
// Debug governor on one AXI-Stream link: pauses, drops and/or logs flits under
// control of a daisy-chained, write-only command bus.
module axis_dbg_guv #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEST_WIDTH  = 16,
   parameter int ID_WIDTH    = 16,
   parameter int CNT_SIZE    = 16,
   parameter int ADDR_WIDTH  = 10,
   parameter int ADDR        = 0,
   parameter int STICKY_MODE = 1,
   parameter int PIPE_STAGE  = 1
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic [DATA_WIDTH-1:0]   cmd_in_TDATA,
   input  logic                    cmd_in_TVALID,
   output logic [DATA_WIDTH-1:0]   cmd_out_TDATA,
   output logic                    cmd_out_TVALID,

   input  logic [DATA_WIDTH-1:0]   in_TDATA,
   input  logic [DATA_WIDTH/8-1:0] in_TKEEP,
   input  logic [DEST_WIDTH-1:0]   in_TDEST,
   input  logic [ID_WIDTH-1:0]     in_TID,
   input  logic                    in_TLAST,
   input  logic                    in_TVALID,
   output logic                    in_TREADY,

   output logic [DATA_WIDTH-1:0]   out_TDATA,
   output logic [DATA_WIDTH/8-1:0] out_TKEEP,
   output logic [DEST_WIDTH-1:0]   out_TDEST,
   output logic [ID_WIDTH-1:0]     out_TID,
   output logic                    out_TLAST,
   output logic                    out_TVALID,
   input  logic                    out_TREADY,

   output logic [DATA_WIDTH+DATA_WIDTH/8+1+DEST_WIDTH+ID_WIDTH-1:0] log_catted_TDATA,
   output logic                    log_catted_TVALID,
   output logic                    log_catted_TLAST,
   input  logic                    log_catted_TREADY
);

   localparam int LOGW = DATA_WIDTH + DATA_WIDTH/8 + 1 + DEST_WIDTH + ID_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] MY_ADDR = ADDR_WIDTH'(ADDR);

   localparam logic [3:0] REG_DROP      = 4'd0;
   localparam logic [3:0] REG_LOG       = 4'd1;
   localparam logic [3:0] REG_PAUSE     = 4'd2;
   localparam logic [3:0] REG_KEEP_DROP = 4'd3;
   localparam logic [3:0] REG_KEEP_LOG  = 4'd4;
   localparam logic [3:0] REG_LATCH     = 4'd5;

   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [3:0]            cmd_reg;
   logic [CNT_SIZE-1:0]   cmd_val;
   logic                  cmd_match;
   logic                  latch;
   logic                  unused_cmd_bits;

   assign cmd_addr  = cmd_in_TDATA[DATA_WIDTH-1 -: ADDR_WIDTH];
   assign cmd_reg   = cmd_in_TDATA[DATA_WIDTH-ADDR_WIDTH-1 -: 4];
   assign cmd_val   = cmd_in_TDATA[CNT_SIZE-1:0];
   assign cmd_match = cmd_in_TVALID && (cmd_addr == MY_ADDR);
   assign latch     = cmd_match && (cmd_reg == REG_LATCH);
   assign unused_cmd_bits = ^cmd_in_TDATA;

   // Commands for other instances travel on; our own are swallowed.
   generate
      if (PIPE_STAGE != 0) begin : g_cmd_pipe
         logic [DATA_WIDTH-1:0] cmd_data_q;
         logic                  cmd_valid_q;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cmd_data_q  <= '0;
               cmd_valid_q <= 1'b0;
            end else begin
               cmd_data_q  <= cmd_in_TDATA;
               cmd_valid_q <= cmd_in_TVALID && !cmd_match;
            end
         end
         assign cmd_out_TDATA  = cmd_data_q;
         assign cmd_out_TVALID = cmd_valid_q;
      end else begin : g_cmd_comb
         assign cmd_out_TDATA  = cmd_in_TDATA;
         assign cmd_out_TVALID = cmd_in_TVALID && !cmd_match;
      end
   endgenerate

   logic [CNT_SIZE-1:0] drop_sh_q, drop_sh_d, log_sh_q, log_sh_d;
   logic                pause_sh_q, pause_sh_d, kdrop_sh_q, kdrop_sh_d, klog_sh_q, klog_sh_d;
   logic [CNT_SIZE-1:0] drop_cnt_q, drop_cnt_d, log_cnt_q, log_cnt_d;
   logic                pause_q, pause_d, kdrop_q, kdrop_d, klog_q, klog_d;
   logic [LOGW-1:0]     log_data_q, log_data_d;
   logic                log_last_q, log_last_d, log_valid_q, log_valid_d;

   logic drop_now, log_now, log_ok, accept;

   assign drop_now = kdrop_q || (drop_cnt_q != '0);
   assign log_now  = klog_q || (log_cnt_q != '0);
   assign log_ok   = !log_now || !log_valid_q || log_catted_TREADY;

   assign in_TREADY  = !pause_q && log_ok && (drop_now || out_TREADY);
   assign out_TVALID = in_TVALID && !pause_q && !drop_now && log_ok;
   assign out_TDATA  = in_TDATA;
   assign out_TKEEP  = in_TKEEP;
   assign out_TDEST  = in_TDEST;
   assign out_TID    = in_TID;
   assign out_TLAST  = in_TLAST;
   assign accept     = in_TVALID && in_TREADY;

   assign log_catted_TDATA  = log_data_q;
   assign log_catted_TVALID = log_valid_q;
   assign log_catted_TLAST  = log_last_q;

   always_comb begin
      drop_sh_d  = drop_sh_q;
      log_sh_d   = log_sh_q;
      pause_sh_d = pause_sh_q;
      kdrop_sh_d = kdrop_sh_q;
      klog_sh_d  = klog_sh_q;
      if (cmd_match) begin
         case (cmd_reg)
            REG_DROP:      drop_sh_d  = cmd_val;
            REG_LOG:       log_sh_d   = cmd_val;
            REG_PAUSE:     pause_sh_d = cmd_val[0];
            REG_KEEP_DROP: kdrop_sh_d = cmd_val[0];
            REG_KEEP_LOG:  klog_sh_d  = cmd_val[0];
            REG_LATCH: begin
               if (STICKY_MODE == 0) begin
                  drop_sh_d  = '0;
                  log_sh_d   = '0;
                  pause_sh_d = 1'b0;
                  kdrop_sh_d = 1'b0;
                  klog_sh_d  = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // A latch in the same cycle as an accept wins over the decrement.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      log_cnt_d  = log_cnt_q;
      pause_d    = pause_q;
      kdrop_d    = kdrop_q;
      klog_d     = klog_q;
      if (accept && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
      if (accept && (log_cnt_q != '0))  log_cnt_d  = log_cnt_q - 1'b1;
      if (latch) begin
         drop_cnt_d = drop_sh_q;
         log_cnt_d  = log_sh_q;
         pause_d    = pause_sh_q;
         kdrop_d    = kdrop_sh_q;
         klog_d     = klog_sh_q;
      end
   end

   always_comb begin
      log_data_d  = log_data_q;
      log_last_d  = log_last_q;
      log_valid_d = log_valid_q;
      if (accept && log_now) begin
         log_data_d  = {in_TID, in_TDEST, in_TLAST, in_TKEEP, in_TDATA};
         log_last_d  = in_TLAST;
         log_valid_d = 1'b1;
      end else if (log_catted_TREADY) begin
         log_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_sh_q   <= '0;
         log_sh_q    <= '0;
         pause_sh_q  <= 1'b0;
         kdrop_sh_q  <= 1'b0;
         klog_sh_q   <= 1'b0;
         drop_cnt_q  <= '0;
         log_cnt_q   <= '0;
         pause_q     <= 1'b0;
         kdrop_q     <= 1'b0;
         klog_q      <= 1'b0;
         log_data_q  <= '0;
         log_last_q  <= 1'b0;
         log_valid_q <= 1'b0;
      end else begin
         drop_sh_q   <= drop_sh_d;
         log_sh_q    <= log_sh_d;
         pause_sh_q  <= pause_sh_d;
         kdrop_sh_q  <= kdrop_sh_d;
         klog_sh_q   <= klog_sh_d;
         drop_cnt_q  <= drop_cnt_d;
         log_cnt_q   <= log_cnt_d;
         pause_q     <= pause_d;
         kdrop_q     <= kdrop_d;
         klog_q      <= klog_d;
         log_data_q  <= log_data_d;
         log_last_q  <= log_last_d;
         log_valid_q <= log_valid_d;
      end
   end

endmodule

// File: tb/tb_axis_dbg_guv.sv
// Scoreboard bench: u0(ADDR0)->u1(ADDR1) command chain plus a non-sticky,
// combinational-forward u2; directed flits with hand-computed expectations.
module tb_axis_dbg_guv;
   localparam int DW = 32;
   localparam int KW = 4;
   localparam int LW = 69;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] cmd_a_data, cmd_b_data, c01_data, c1o_data, c2o_data;
   logic          cmd_a_valid, cmd_b_valid, c01_valid, c1o_valid, c2o_valid;

   logic [2:0][DW-1:0] in_data, out_data;
   logic [2:0][KW-1:0] in_keep, out_keep;
   logic [2:0][15:0]   in_dest, out_dest, in_id, out_id;
   logic [2:0]         in_last, out_last, in_valid, in_ready, out_valid, out_ready;
   logic [2:0][LW-1:0] log_data;
   logic [2:0]         log_valid, log_last, log_ready;

   axis_dbg_guv #(.ADDR(0), .STICKY_MODE(1), .PIPE_STAGE(1)) u0 (
      .clk(clk), .rst(rst),
      .cmd_in_TDATA(cmd_a_data), .cmd_in_TVALID(cmd_a_valid),
      .cmd_out_TDATA(c01_data), .cmd_out_TVALID(c01_valid),
      .in_TDATA(in_data[0]), .in_TKEEP(in_keep[0]), .in_TDEST(in_dest[0]), .in_TID(in_id[0]),
      .in_TLAST(in_last[0]), .in_TVALID(in_valid[0]), .in_TREADY(in_ready[0]),
      .out_TDATA(out_data[0]), .out_TKEEP(out_keep[0]), .out_TDEST(out_dest[0]), .out_TID(out_id[0]),
      .out_TLAST(out_last[0]), .out_TVALID(out_valid[0]), .out_TREADY(out_ready[0]),
      .log_catted_TDATA(log_data[0]), .log_catted_TVALID(log_valid[0]),
      .log_catted_TLAST(log_last[0]), .log_catted_TREADY(log_ready[0]));

   axis_dbg_guv #(.ADDR(1), .STICKY_MODE(1), .PIPE_STAGE(1)) u1 (
      .clk(clk), .rst(rst),
      .cmd_in_TDATA(c01_data), .cmd_in_TVALID(c01_valid),
      .cmd_out_TDATA(c1o_data), .cmd_out_TVALID(c1o_valid),
      .in_TDATA(in_data[1]), .in_TKEEP(in_keep[1]), .in_TDEST(in_dest[1]), .in_TID(in_id[1]),
      .in_TLAST(in_last[1]), .in_TVALID(in_valid[1]), .in_TREADY(in_ready[1]),
      .out_TDATA(out_data[1]), .out_TKEEP(out_keep[1]), .out_TDEST(out_dest[1]), .out_TID(out_id[1]),
      .out_TLAST(out_last[1]), .out_TVALID(out_valid[1]), .out_TREADY(out_ready[1]),
      .log_catted_TDATA(log_data[1]), .log_catted_TVALID(log_valid[1]),
      .log_catted_TLAST(log_last[1]), .log_catted_TREADY(log_ready[1]));

   axis_dbg_guv #(.ADDR(0), .STICKY_MODE(0), .PIPE_STAGE(0)) u2 (
      .clk(clk), .rst(rst),
      .cmd_in_TDATA(cmd_b_data), .cmd_in_TVALID(cmd_b_valid),
      .cmd_out_TDATA(c2o_data), .cmd_out_TVALID(c2o_valid),
      .in_TDATA(in_data[2]), .in_TKEEP(in_keep[2]), .in_TDEST(in_dest[2]), .in_TID(in_id[2]),
      .in_TLAST(in_last[2]), .in_TVALID(in_valid[2]), .in_TREADY(in_ready[2]),
      .out_TDATA(out_data[2]), .out_TKEEP(out_keep[2]), .out_TDEST(out_dest[2]), .out_TID(out_id[2]),
      .out_TLAST(out_last[2]), .out_TVALID(out_valid[2]), .out_TREADY(out_ready[2]),
      .log_catted_TDATA(log_data[2]), .log_catted_TVALID(log_valid[2]),
      .log_catted_TLAST(log_last[2]), .log_catted_TREADY(log_ready[2]));

   typedef struct {
      int            d;
      logic          last;
      logic [LW-1:0] v;
   } exp_t;

   exp_t out_q[$];
   exp_t log_q[$];
   exp_t e_out, e_log;
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %h required %h", name, act, exp);
      end
   endtask

   task automatic push_out(input int d, input logic [DW-1:0] v);
      exp_t e;
      e.d = d; e.last = 1'b0; e.v = LW'(v);
      out_q.push_back(e);
   endtask

   task automatic push_log(input int d, input logic last, input logic [LW-1:0] v);
      exp_t e;
      e.d = d; e.last = last; e.v = v;
      log_q.push_back(e);
   endtask

   // Monitor: pops the scoreboard whenever any DUT completes an out or log handshake.
   always @(negedge clk) begin
      if (rst) begin
         for (int d = 0; d < 3; d++) begin
            if (out_valid[d] && out_ready[d]) begin
               if (out_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL out_extra dut%0d got %h required none", d, out_data[d]);
               end else begin
                  e_out = out_q.pop_front();
                  check($sformatf("out_dut dut%0d", d), LW'(d), LW'(e_out.d));
                  check($sformatf("out_data dut%0d", d), LW'(out_data[d]), e_out.v);
                  $display("[TB] out dut%0d data %h", d, out_data[d]);
               end
            end
            if (log_valid[d] && log_ready[d]) begin
               if (log_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL log_extra dut%0d got %h required none", d, log_data[d]);
               end else begin
                  e_log = log_q.pop_front();
                  check($sformatf("log_dut dut%0d", d), LW'(d), LW'(e_log.d));
                  check($sformatf("log_data dut%0d", d), log_data[d], e_log.v);
                  check($sformatf("log_last dut%0d", d), LW'(log_last[d]), LW'(e_log.last));
                  $display("[TB] log dut%0d data %h", d, log_data[d]);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input int bus, input int addr, input int rg, input int val);
      logic [DW-1:0] w;
      w = {10'(addr), 4'(rg), 2'b00, 16'(val)};
      if (bus == 0) begin
         cmd_a_data = w; cmd_a_valid = 1'b1;
      end else begin
         cmd_b_data = w; cmd_b_valid = 1'b1;
      end
      tick();
      cmd_a_valid = 1'b0;
      cmd_b_valid = 1'b0;
      $display("[TB] cmd bus%0d addr %0d reg %0d val %0d", bus, addr, rg, val);
   endtask

   task automatic send(input int d, input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         int t;
         bit done;
         in_data[d] = base + DW'(i);
         in_valid[d] = 1'b1;
         t = 0;
         done = 0;
         while (!done) begin
            @(negedge clk);
            if (in_ready[d]) begin
               @(posedge clk); #1;
               done = 1;
            end else begin
               t++;
               if (t > 40) begin
                  tests++; fails++;
                  $display("FAIL send_timeout dut%0d data %h in_TREADY 0 required 1", d, base + DW'(i));
                  @(posedge clk); #1;
                  done = 1;
               end
            end
         end
      end
      in_valid[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_a_data = '0; cmd_a_valid = 1'b0;
      cmd_b_data = '0; cmd_b_valid = 1'b0;
      in_data = '0; in_keep = '0; in_dest = '0; in_id = '0; in_last = '0;
      in_valid = '0; out_ready = '1; log_ready = '1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_log_valid", LW'(log_valid), LW'(0));
      check("rst_cmd_out_valid", LW'(c01_valid), LW'(0));
      check("rst_out_valid", LW'(out_valid), LW'(0));
      rst = 1'b1;
      tick();

      // T1: transparent pass-through
      out_ready[0] = 1'b0; in_valid[0] = 1'b1; #1;
      check("pass_ready_low", LW'(in_ready[0]), LW'(0));
      check("pass_valid", LW'(out_valid[0]), LW'(1));
      out_ready[0] = 1'b1; #1;
      check("pass_ready_high", LW'(in_ready[0]), LW'(1));
      in_valid[0] = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) push_out(0, 32'h10 + 32'(i));
      send(0, 4, 32'h10);

      // T2: drop exactly three flits
      cmd(0, 0, 0, 3);
      cmd(0, 0, 5, 0);
      push_out(0, 32'h23); push_out(0, 32'h24); push_out(0, 32'h25);
      send(0, 6, 32'h20);

      // T3: log two flits on ADDR 1 through the chain
      in_keep[1] = 4'h1; in_dest[1] = 16'h1; in_id[1] = 16'h1; in_last[1] = 1'b0;
      cmd(0, 1, 1, 2);
      cmd(0, 1, 5, 0);
      tick();
      push_out(1, 32'h1); push_out(1, 32'h2); push_out(1, 32'h3);
      push_log(1, 1'b0, {16'h0001, 16'h0001, 1'b0, 4'h1, 32'h0000_0001});
      push_log(1, 1'b0, {16'h0001, 16'h0001, 1'b0, 4'h1, 32'h0000_0002});
      send(1, 3, 32'h1);

      // T4: forwarding and consumption in the chain
      cmd(0, 1, 0, 7);
      check("fwd_valid", LW'(c01_valid), LW'(1));
      check("fwd_data", LW'(c01_data), LW'(32'h0040_0007));
      tick();
      check("fwd_valid_drop", LW'(c01_valid), LW'(0));
      cmd(0, 0, 6, 0);
      check("own_not_fwd", LW'(c01_valid), LW'(0));
      push_out(0, 32'h30); push_out(0, 32'h31);
      send(0, 2, 32'h30);

      // T5: pause then resume without loss
      cmd(0, 0, 0, 0);
      cmd(0, 0, 2, 1);
      cmd(0, 0, 5, 0);
      in_data[0] = 32'h40; in_valid[0] = 1'b1;
      repeat (3) tick();
      check("pause_ready", LW'(in_ready[0]), LW'(0));
      check("pause_valid", LW'(out_valid[0]), LW'(0));
      cmd(0, 0, 2, 0);
      cmd(0, 0, 5, 0);
      push_out(0, 32'h40); push_out(0, 32'h41); push_out(0, 32'h42);
      send(0, 3, 32'h40);

      // T6: non-sticky shadows, then keep_log backpressure
      in_keep[2] = 4'hF; in_dest[2] = 16'h2; in_id[2] = 16'h3; in_last[2] = 1'b1;
      cmd(1, 0, 0, 2);
      cmd(1, 0, 5, 0);
      send(2, 1, 32'h50);
      cmd(1, 0, 5, 0);
      push_out(2, 32'h51); push_out(2, 32'h52);
      send(2, 2, 32'h51);

      cmd(1, 0, 4, 1);
      cmd(1, 0, 5, 0);
      log_ready[2] = 1'b0;
      push_out(2, 32'h70);
      push_log(2, 1'b1, {16'h0003, 16'h0002, 1'b1, 4'hF, 32'h0000_0070});
      send(2, 1, 32'h70);
      in_data[2] = 32'h71; in_valid[2] = 1'b1;
      repeat (3) tick();
      check("logbp_ready", LW'(in_ready[2]), LW'(0));
      check("logbp_log_valid", LW'(log_valid[2]), LW'(1));
      check("logbp_out_valid", LW'(out_valid[2]), LW'(0));
      log_ready[2] = 1'b1;
      push_out(2, 32'h71); push_out(2, 32'h72);
      push_log(2, 1'b1, {16'h0003, 16'h0002, 1'b1, 4'hF, 32'h0000_0071});
      push_log(2, 1'b1, {16'h0003, 16'h0002, 1'b1, 4'hF, 32'h0000_0072});
      send(2, 2, 32'h71);

      repeat (5) tick();
      check("out_queue_empty", LW'(out_q.size()), LW'(0));
      check("log_queue_empty", LW'(log_q.size()), LW'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
